// File: rtl/dm_wt_cache_if.sv
// dm_wt_cache_if: groups the processor-side and stallmem-side buses of the
// direct-mapped write-through cache into one bundle.
//
// Signals:
//   cpu_addr/cpu_wdata/cpu_rd/cpu_wr/flush : processor request
//   cpu_rdata/cpu_done                     : processor response
//   mem_addr/mem_wdata/mem_enable/mem_wr   : stallmem request
//   mem_rdata/mem_ready                    : stallmem response
//
// Modports:
//   slave  : the cache (consumes the processor request, drives stallmem)
//   master : the environment (processor plus stallmem)
interface dm_wt_cache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              flush;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_enable;
  logic              mem_wr;
  logic              mem_ready;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, flush, mem_rdata, mem_ready,
    output cpu_rdata, cpu_done, mem_addr, mem_wdata, mem_enable, mem_wr
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, flush, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_done, mem_addr, mem_wdata, mem_enable, mem_wr
  );
endinterface

// File: rtl/dm_wt_cache.sv
// dm_wt_cache: direct-mapped, write-through, one-word-line cache placed
// between the processor memory port and the stallmem backing memory.
// Read hits complete in the request cycle; read misses and all writes go to
// stallmem and complete in the mem_ready cycle (writes allocate the line).
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : dm_wt_cache_if.slave (processor request/response, stallmem bus)
//   hit_count/miss_count : read hit / read miss counters, only present when
//                          the CACHE_STATS_EN macro is defined
//
// Optional feature macro: CACHE_STATS_EN
module dm_wt_cache #(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  dm_wt_cache_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              mem_enable_reg;
  logic              mem_wr_reg;

  logic [LINES-1:0]  valid_reg;
  logic [TAG_W-1:0]  tag_reg  [LINES];
  logic [DATA_W-1:0] data_reg [LINES];

  logic [INDEX_BITS-1:0] cpu_index;
  logic [TAG_W-1:0]      cpu_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_W-1:0]      fill_tag;
  logic [DATA_W-1:0]     fill_data;
  logic                  line_hit;
  logic                  rd_hit;
  logic                  mem_done;
  logic                  flush_now;
  logic [DATA_W-1:0]     rdata_next;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^bus.cpu_addr[1:0];

  assign cpu_index  = bus.cpu_addr[INDEX_BITS+1:2];
  assign cpu_tag    = bus.cpu_addr[ADDR_W-1:INDEX_BITS+2];
  // The latched request address doubles as the fill address.
  assign fill_index = mem_addr_reg[INDEX_BITS+1:2];
  assign fill_tag   = mem_addr_reg[ADDR_W-1:INDEX_BITS+2];

  always_comb begin
    line_hit   = valid_reg[cpu_index] && (tag_reg[cpu_index] == cpu_tag);
    // A simultaneous write takes priority, so a hit only completes a pure read.
    rd_hit     = (state_reg == IDLE) && bus.cpu_rd && !bus.cpu_wr && line_hit && !rst;
    mem_done   = (state_reg != IDLE) && bus.mem_ready && !rst;
    flush_now  = (state_reg == IDLE) && bus.flush && !bus.cpu_rd && !bus.cpu_wr;
    fill_data  = (state_reg == WR_THRU) ? mem_wdata_reg : bus.mem_rdata;
    rdata_next = '0;
    if (rd_hit) begin
      rdata_next = data_reg[cpu_index];
    end else if (mem_done && (state_reg == RD_MISS)) begin
      rdata_next = bus.mem_rdata;
    end
  end

  assign bus.cpu_done   = rd_hit || mem_done;
  assign bus.cpu_rdata  = rdata_next;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;
  assign bus.mem_enable = mem_enable_reg;
  assign bus.mem_wr     = mem_wr_reg;

  // Valid bits are per-line flops so flush and reset clear them in one edge.
  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (rst || flush_now) begin
          valid_reg[gi] <= 1'b0;
        end else if (mem_done && (fill_index == INDEX_BITS'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (mem_done) begin
      tag_reg[fill_index]  <= fill_tag;
      data_reg[fill_index] <= fill_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_enable_reg <= 1'b0;
      mem_wr_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.cpu_wr) begin
            state_reg      <= WR_THRU;
            mem_addr_reg   <= bus.cpu_addr;
            mem_wdata_reg  <= bus.cpu_wdata;
            mem_enable_reg <= 1'b1;
            mem_wr_reg     <= 1'b1;
          end else if (bus.cpu_rd && !line_hit) begin
            state_reg      <= RD_MISS;
            mem_addr_reg   <= bus.cpu_addr;
            mem_enable_reg <= 1'b1;
            mem_wr_reg     <= 1'b0;
          end
        end
        RD_MISS, WR_THRU: begin
          if (bus.mem_ready) begin
            state_reg      <= IDLE;
            mem_enable_reg <= 1'b0;
            mem_wr_reg     <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit) hit_count <= hit_count + 32'd1;
      if (mem_done && (state_reg == RD_MISS)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_wt_cache.sv
// tb_dm_wt_cache: directed self-checking bench for dm_wt_cache with a small
// stallmem model (programmable latency, 256 words, reset-initialised).
module tb_dm_wt_cache;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_wt_cache_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dm_wt_cache #(.INDEX_BITS(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 1;
  int wait_cnt;
  logic [31:0] mem [256];

  // stallmem model: word i holds 0xA000_0000+i except word 16 (0x40).
  always @(posedge clk) begin
    if (rst) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      wait_cnt      <= 0;
      for (int i = 0; i < 256; i++)
        mem[i] <= (i == 16) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(i);
    end else if (bus.mem_enable && !bus.mem_ready) begin
      if (wait_cnt >= mem_lat) begin
        bus.mem_ready <= 1'b1;
        wait_cnt      <= 0;
        if (bus.mem_wr) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        else            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      bus.mem_ready <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp,
                          input bit exp_hit, input bit with_flush, input string tag);
    bit got_done;
    got_done = 1'b0;
    @(posedge clk); #1;
    bus.cpu_addr = a;
    bus.cpu_rd   = 1'b1;
    bus.flush    = with_flush;
    @(negedge clk);
    if (exp_hit) begin
      check({tag, " hit_done"},  32'(bus.cpu_done),   32'd1);
      check({tag, " hit_rdata"}, bus.cpu_rdata,       exp);
      check({tag, " hit_men"},   32'(bus.mem_enable), 32'd0);
    end else begin
      check({tag, " acc_done"}, 32'(bus.cpu_done), 32'd0);
      @(negedge clk);
      check({tag, " mem_en"},   32'(bus.mem_enable), 32'd1);
      check({tag, " mem_wr"},   32'(bus.mem_wr),     32'd0);
      check({tag, " mem_addr"}, bus.mem_addr,        a);
      for (int i = 0; i < 40 && !got_done; i++) begin
        if (bus.cpu_done) got_done = 1'b1;
        else @(negedge clk);
      end
      check({tag, " done"},  32'(got_done), 32'd1);
      check({tag, " rdata"}, bus.cpu_rdata, exp);
    end
    $display("[TB] %s rd addr=%h rdata=%h done=%0d", tag, a, bus.cpu_rdata, bus.cpu_done);
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0;
    bus.flush  = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input string tag);
    bit got_done;
    got_done = 1'b0;
    @(posedge clk); #1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_wr    = 1'b1;
    @(negedge clk);
    check({tag, " acc_done"}, 32'(bus.cpu_done), 32'd0);
    @(negedge clk);
    check({tag, " mem_en"},    32'(bus.mem_enable), 32'd1);
    check({tag, " mem_wr"},    32'(bus.mem_wr),     32'd1);
    check({tag, " mem_addr"},  bus.mem_addr,        a);
    check({tag, " mem_wdata"}, bus.mem_wdata,       d);
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (bus.cpu_done) got_done = 1'b1;
      else @(negedge clk);
    end
    check({tag, " done"}, 32'(got_done), 32'd1);
    $display("[TB] %s wr addr=%h wdata=%h done=%0d", tag, a, d, bus.cpu_done);
    @(posedge clk); #1;
    bus.cpu_wr = 1'b0;
  endtask

  initial begin
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst done",      32'(bus.cpu_done),   32'd0);
    check("rst rdata",     bus.cpu_rdata,       32'd0);
    check("rst mem_en",    32'(bus.mem_enable), 32'd0);
    check("rst mem_wr",    32'(bus.mem_wr),     32'd0);
    check("rst mem_addr",  bus.mem_addr,        32'd0);
    check("rst mem_wdata", bus.mem_wdata,       32'd0);
    $display("[TB] reset released");

    // Cold miss, then zero-wait hit.
    cpu_read(32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0, "cold");
    cpu_read(32'h40, 32'hDEAD_BEEF, 1'b1, 1'b0, "hit");
`ifdef CACHE_STATS_EN
    check("stat hit",  hit_count,  32'd1);
    check("stat miss", miss_count, 32'd1);
`endif

    // Conflict: 0x80 shares index 0 with 0x40.
    cpu_read(32'h80, 32'hA000_0020, 1'b0, 1'b0, "conf80");
    cpu_read(32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0, "conf40");
    cpu_read(32'h80, 32'hA000_0020, 1'b0, 1'b0, "conf80b");

    // Write-through with allocate, then hit on the written word.
    mem_lat = 3;
    cpu_write(32'h44, 32'h1234_5678, "wr44");
    cpu_read(32'h44, 32'h1234_5678, 1'b1, 1'b0, "rd44");
    cpu_read(32'h48, 32'hA000_0012, 1'b0, 1'b0, "rd48");
    cpu_read(32'h44, 32'h1234_5678, 1'b1, 1'b0, "rd44b");

    // Flush in an idle cycle invalidates; flush alongside a read is ignored.
    mem_lat = 1;
    cpu_read(32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0, "fill40");
    @(posedge clk); #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    $display("[TB] flush pulse");
    cpu_read(32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0, "postflush");
    cpu_read(32'h40, 32'hDEAD_BEEF, 1'b1, 1'b1, "flushrd");
    cpu_read(32'h40, 32'hDEAD_BEEF, 1'b1, 1'b0, "afterign");

    // Reset in the middle of a miss.
    mem_lat = 6;
    @(posedge clk); #1;
    bus.cpu_addr = 32'h100;
    bus.cpu_rd   = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmiss men_before", 32'(bus.mem_enable), 32'd1);
    @(posedge clk); #1;
    rst        = 1'b1;
    bus.cpu_rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmiss men_after", 32'(bus.mem_enable), 32'd0);
    check("rstmiss done",      32'(bus.cpu_done),   32'd0);
`ifdef CACHE_STATS_EN
    check("rstmiss hit_cnt",  hit_count,  32'd0);
    check("rstmiss miss_cnt", miss_count, 32'd0);
`endif
    $display("[TB] reset mid-miss applied");
    mem_lat = 1;
    cpu_read(32'h100, 32'hA000_0040, 1'b0, 1'b0, "reread100");
    cpu_read(32'h40,  32'hDEAD_BEEF, 1'b0, 1'b0, "coldagain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dm_wt_cache.md
Name: dm_wt_cache

Overview:
- Direct-mapped, write-through, one-word-line cache between the proc memory port and the stallmem backing memory.
- Read hits return in zero wait cycles. Read misses and all writes go to stallmem and stall the processor until mem_ready.
- Replaces the direct proc-to-stallmem connection; the stallmem protocol on the memory side is unchanged.

Parameters:
- INDEX_BITS, 4, number of index bits; number of lines = 2**INDEX_BITS (default 16).
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cpu_addr  in  ADDR_W  processor byte address; bits [1:0] ignored.
- cpu_wdata  in  DATA_W  processor write data.
- cpu_rd  in  1  read request; held with addr stable until cpu_done.
- cpu_wr  in  1  write request; held with addr/wdata stable until cpu_done.
- cpu_rdata  out  DATA_W  read data; valid only when cpu_done=1 for a read.
- cpu_done  out  1  request complete this cycle.
- flush  in  1  invalidate all lines; honoured only in IDLE with no request present.
- mem_addr  out  ADDR_W  to stallmem addr.
- mem_wdata  out  DATA_W  to stallmem data_in.
- mem_rdata  in  DATA_W  from stallmem data_out.
- mem_enable  out  1  stallmem enable.
- mem_wr  out  1  stallmem write flag.
- mem_ready  in  1  stallmem ready; read data valid in the same cycle.

Behaviour:
- Address split:
  - index = cpu_addr[INDEX_BITS+1:2]
  - tag = cpu_addr[ADDR_W-1:INDEX_BITS+2]
- Per-line storage: valid bit, tag, data word. Storage is register-based with asynchronous read.
- Reset:
  - state=IDLE; all valid bits=0.
  - cpu_done=0, mem_enable=0, mem_wr=0, cpu_rdata=0.
  - mem_addr=0, mem_wdata=0.
- IDLE:
  - hit = valid[index] && tag match.
  - cpu_rd && hit: cpu_done=1 combinationally in the same cycle; cpu_rdata=line data; no state change. Zero-wait hit.
  - cpu_rd && !hit: latch addr; go to RD_MISS next cycle.
  - cpu_wr (also if cpu_rd=1; write has priority): latch addr and wdata; go to WR_THRU next cycle.
  - flush && !cpu_rd && !cpu_wr: clear all valid bits at the clock edge. No effect in any other case.
- RD_MISS:
  - mem_enable=1, mem_wr=0, mem_addr=latched addr. All memory outputs registered and stable until mem_ready.
  - On mem_ready: install line (valid=1, tag, data=mem_rdata); cpu_done=1; cpu_rdata=mem_rdata (forwarded the same cycle); next state IDLE.
- WR_THRU:
  - mem_enable=1, mem_wr=1, mem_addr/mem_wdata=latched values.
  - On mem_ready: install line (write-allocate, valid=1); cpu_done=1; next state IDLE.
- Outside the mem_ready cycle, memory outputs return to mem_enable=0 and mem_wr=0 in IDLE.
- Back-to-back: a new request is evaluated in the cycle after cpu_done. The processor deasserts or changes the request after seeing cpu_done.
- cpu_done is never 1 in the cycle a miss or write is first accepted. Minimum miss latency is 1 + stallmem latency cycles.
- Reset mid-miss:
  - Go to IDLE; mem_enable drops the next cycle; no line installed.
  - A late mem_ready is ignored in IDLE.
- mem_ready in IDLE: ignored.
- Line replacement is a silent overwrite. No dirty state exists (write-through).

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on every read hit cpu_done cycle.
  - miss_count increments on every RD_MISS cpu_done cycle.
  - Both counters wrap at 2**32; cleared by rst, not by flush.
  - Writes are not counted.
- Undefined: no such ports or counter logic; behaviour otherwise identical.

Test Plan:
- Cold read: after reset, cpu_rd addr 0x0000_0040 with stallmem holding 0xDEADBEEF -> cpu_done=0 in the accept cycle; RD_MISS drives mem_addr=0x40; cpu_done=1 with cpu_rdata=0xDEADBEEF in the mem_ready cycle.
- Hit: repeat read 0x40 -> cpu_done=1 in the same cycle; mem_enable stays 0; rdata=0xDEADBEEF; with CACHE_STATS_EN, hit_count=1 and miss_count=1.
- Conflict: read 0x40, then 0x80 (same index 0 with INDEX_BITS=4, different tag), then 0x40 -> all three miss; mem_enable is asserted each time.
- Write-through: write 0x12345678 to 0x44 -> mem_wr=1, mem_addr=0x44, mem_wdata=0x12345678 until mem_ready; cpu_done=1 then; a following read of 0x44 hits with 0x12345678.
- Flush: fill 0x40, assert flush for one idle cycle, read 0x40 -> miss. Also assert flush together with cpu_rd -> flush ignored, read serviced.
- Reset mid-miss: start a miss on 0x100 and pulse rst before mem_ready -> mem_enable=0 the next cycle; a later read of 0x100 misses again; counters are 0.
